par_checking_sink: RTL and testbench
====================================

// Module: par_checking_sink
// PURPOSE
// - Local-port consumer for one NoC node: accepts flits from router local output (tx_data_l/tx_valid_l).
// - Buffers flits, drains at a rate set by a hospitality LFSR, checks destination address, counts traffic.
// - Sits directly downstream of async_router local port, in that router's clk domain; one per node.
// - Replaces par_moody_sink when per-node checking and statistics are wanted.
// PARAMETERS
// - ID         0    node index; expected destination address of every flit
// - SINK_HOSP  255  drain probability 0-255; 255 = drain every cycle, 0 = never drain
// - DEPTH      4    input buffer depth in flits, power of 2, >= 2
// - TS_W       16   timestamp width in payload LSBs (latency feature only)
// PORTS
// - clk        in   1            node clock
// - reset      in   1            synchronous, active-high
// - in_data    in   `HDR_SZ+`PL_SZ+`ADDR_SZ  flit {hdr, payload, dest}; dest = [`ADDR_SZ-1:0]
// - in_valid   in   1            flit present on in_data
// - busy       out  1            sink cannot accept; upstream holds flit
// - out_data   out  `HDR_SZ+`PL_SZ+`ADDR_SZ  flit drained this cycle (scoreboard tap)
// - out_valid  out  1            one-cycle pulse per drained flit
// - rx_count   out  20           flits drained, saturating
// - err_count  out  16           drained flits with dest != ID, saturating
// - err_flag   out  1            sticky, set on first misrouted flit
// - lat_sum    out  32           sum of flit latencies (0 without feature)
// - lat_max    out  TS_W         max flit latency (0 without feature)
// BEHAVIOUR
// - Reset: buffer empty, busy=0, out_valid=0, out_data=0, all counters/flags 0, LFSR=ID+1 (never 0), state IDLE.
// - Accept: transfer on rising clk when in_valid && !busy; flit written to buffer tail.
// - busy = (count == DEPTH), derived from registered count; in_valid while busy = no write, no loss.
// - Drain gate: 8-bit Fibonacci LFSR (taps 8,6,5,4) steps every cycle; go = (SINK_HOSP==255) || (lfsr < SINK_HOSP).
// - States: IDLE (buffer empty), DRAIN (non-empty, go=1: pop head), STALL (non-empty, go=0: hold).
// - Transitions evaluated each cycle from post-update count and go; IDLE->DRAIN earliest one cycle after first write.
// - Latency: write-to-out_valid minimum 1 cycle; out_data/out_valid registered, valid exactly one cycle per pop.
// - Simultaneous push+pop when full: pop frees slot but busy reflects pre-pop count; no push that cycle.
// - Simultaneous push+pop when non-full: both occur, count unchanged; pointers wrap modulo DEPTH.
// - Check at pop: dest != ID -> err_count+1, err_flag=1; rx_count+1 for every pop regardless.
// - Counters saturate at all-ones; never wrap.
// - Reset mid-operation: buffered flits discarded, counters cleared, busy deasserts next cycle.
// CONFIGURATION
// - `SINK_LATENCY_EN defined: free-running TS_W cycle counter from reset; at pop,
//   lat = now - payload[TS_W-1:0] modulo 2^TS_W; lat_sum += lat (saturating 32b); lat_max = max(lat_max, lat).
// - Not defined: timestamp counter and latency logic absent; lat_sum and lat_max tied to 0.
// STRUCTURE
// - constants.v: `HDR_SZ, `PL_SZ, `ADDR_SZ plus new `SINK_ST_IDLE/DRAIN/STALL (2-bit) encodings.
// - One sub-module: fifo (shared buffer, width = flit width, depth DEPTH); LFSR, FSM, checker inline.
// TESTING
// - Reset, ID=4, SINK_HOSP=255, feed 10 flits dest=4 back-to-back -> 10 out_valid pulses in order, rx_count=10, err_count=0, busy never 1.
// - SINK_HOSP=0, feed 6 flits -> busy=1 after 4th accepted, flits 5-6 held, out_valid never pulses, state STALL.
// - ID=4, one flit dest=7 among 5 valid -> err_count=1, err_flag=1 and stays 1 after further good flits; rx_count=6.
// - Full buffer, hosp=255, in_valid held -> one pop and no push same cycle; push next cycle; no flit lost or duplicated.
// - Assert reset with 3 flits buffered -> next cycle busy=0, rx_count=0, no out_valid for discarded flits.
// - `SINK_LATENCY_EN, inject flit with payload ts=now-5 -> lat_max=5+buffer delay, lat_sum equals sum of per-flit latencies.

Source files
------------

// File: rtl/par_checking_sink_pkg.sv
// Shared definitions for the par_checking_sink NoC local-port consumer.
//
// Contents:
//   HDR_SZ / PL_SZ / ADDR_SZ : flit field widths; flit = {hdr, payload, dest}
//   FLIT_W                   : total flit width
//   sink_state_t             : 2-bit drain FSM encoding (IDLE / DRAIN / STALL)
//   lfsr_step()              : one step of the 8-bit Fibonacci drain-gate LFSR
//
// Optional feature macro used by the top level: SINK_LATENCY_EN.
package par_checking_sink_pkg;

    localparam int HDR_SZ  = 2;
    localparam int PL_SZ   = 24;
    localparam int ADDR_SZ = 4;
    localparam int FLIT_W  = HDR_SZ + PL_SZ + ADDR_SZ;

    typedef enum logic [1:0] {
        SINK_ST_IDLE  = 2'd0,   // buffer empty
        SINK_ST_DRAIN = 2'd1,   // buffer non-empty, pop head this cycle
        SINK_ST_STALL = 2'd2    // buffer non-empty, drain gate closed
    } sink_state_t;

    // Taps 8,6,5,4 (maximal length); state shifts towards the MSB and the
    // feedback enters at bit 0. A non-zero seed never reaches zero.
    function automatic logic [7:0] lfsr_step(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

endpackage

// File: rtl/par_checking_sink_fifo.sv
// Flit buffer for par_checking_sink: circular buffer, DEPTH entries of WIDTH
// bits, DEPTH a power of two so the pointers wrap naturally.
//
// Ports:
//   clk, reset  : clock, synchronous active-high reset (empties the buffer)
//   push        : write wr_data at the tail (ignored when full)
//   pop         : drop the head entry (ignored when empty)
//   wr_data     : data written on push
//   rd_data     : current head entry (valid whenever count != 0)
//   count       : registered occupancy
//   count_next  : occupancy after this cycle's push/pop
//
// A pop does not make room for a push in the same cycle when full: the
// write is refused based on the registered occupancy.
module par_checking_sink_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic [$clog2(DEPTH):0]   count_next
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt_q;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && (cnt_q != FULL);
    assign do_pop  = pop && (cnt_q != '0);

    always_comb begin
        count_next = cnt_q;
        case ({do_push, do_pop})
            2'b10:   count_next = cnt_q + {{AW{1'b0}}, 1'b1};
            2'b01:   count_next = cnt_q - {{AW{1'b0}}, 1'b1};
            default: count_next = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + {{(AW-1){1'b0}}, 1'b1};
            if (do_pop)  rd_ptr <= rd_ptr + {{(AW-1){1'b0}}, 1'b1};
            cnt_q <= count_next;
        end
    end

    // Storage carries no reset; contents are only observed while count != 0.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

    assign rd_data = mem[rd_ptr];
    assign count   = cnt_q;

endmodule

// File: rtl/par_checking_sink.sv
// par_checking_sink: local-port consumer for one NoC node. Buffers flits
// from the router local output, drains them at a rate set by an 8-bit LFSR
// "hospitality" gate, checks each drained flit's destination against ID and
// keeps saturating traffic statistics.
//
// Parameters: ID (expected dest), SINK_HOSP (0..255 drain probability,
// 255 = every cycle), DEPTH (buffer depth, power of 2, >= 2), TS_W
// (timestamp width in payload LSBs).
//
// Ports:
//   clk, reset   : node clock, synchronous active-high reset
//   in_data      : incoming flit {hdr, payload, dest}
//   in_valid     : flit present; transferred on a clock edge when !busy
//   busy         : buffer full; upstream must hold its flit
//   out_data     : flit drained this cycle (held between pulses)
//   out_valid    : one-cycle pulse per drained flit
//   rx_count     : drained flits, saturating
//   err_count    : drained flits whose dest != ID, saturating
//   err_flag     : sticky, set by the first misrouted flit
//   lat_sum      : saturating sum of flit latencies
//   lat_max      : largest flit latency seen
//   state        : drain FSM state (sink_state_t encoding)
//
// Handshake: in_valid/busy form a valid/ready pair with ready = !busy; a flit
// moves on the rising edge where in_valid is high and busy is low, otherwise
// the upstream keeps the same flit on in_data.
//
// Build option: define SINK_LATENCY_EN to add a free-running TS_W timestamp
// counter; at pop, latency = now - payload[TS_W-1:0] (mod 2^TS_W). Without
// it lat_sum and lat_max are constant zero.
module par_checking_sink
    import par_checking_sink_pkg::*;
#(
    parameter int ID        = 0,
    parameter int SINK_HOSP = 255,
    parameter int DEPTH     = 4,
    parameter int TS_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [FLIT_W-1:0] in_data,
    input  logic              in_valid,
    output logic              busy,
    output logic [FLIT_W-1:0] out_data,
    output logic              out_valid,
    output logic [19:0]       rx_count,
    output logic [15:0]       err_count,
    output logic              err_flag,
    output logic [31:0]       lat_sum,
    output logic [TS_W-1:0]   lat_max,
    output logic [1:0]        state
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0]      FULL      = DEPTH[CW-1:0];
    localparam logic [7:0]         ID_PLUS1  = 8'(ID + 1);
    // The LFSR must never hold zero, so an ID of 255 seeds with 1 instead.
    localparam logic [7:0]         LFSR_SEED = (ID_PLUS1 == 8'd0) ? 8'd1 : ID_PLUS1;
    localparam logic [ADDR_SZ-1:0] MY_ADDR   = ADDR_SZ'(ID);

    logic [FLIT_W-1:0] head;
    logic [CW-1:0]     fifo_count;
    logic [CW-1:0]     fifo_count_next;
    logic              push;
    logic              pop;
    logic [7:0]        lfsr;
    logic [7:0]        lfsr_next;
    logic              go_next;
    sink_state_t       st_q;
    sink_state_t       st_d;

    function automatic logic hosp_go(input logic [7:0] l);
        return (SINK_HOSP >= 255) || (int'(l) < SINK_HOSP);
    endfunction

    // busy comes straight from the registered occupancy, so a pop in the
    // same cycle never opens the door for a push while full.
    assign busy  = (fifo_count == FULL);
    assign push  = in_valid && !busy;
    assign pop   = (st_q == SINK_ST_DRAIN);
    assign state = st_q;

    par_checking_sink_fifo #(
        .WIDTH (FLIT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .pop        (pop),
        .wr_data    (in_data),
        .rd_data    (head),
        .count      (fifo_count),
        .count_next (fifo_count_next)
    );

    // Drain gate: the LFSR steps every cycle; the gate for the coming cycle
    // is taken from the value the LFSR will hold then.
    assign lfsr_next = lfsr_step(lfsr);
    assign go_next   = hosp_go(lfsr_next);

    always_ff @(posedge clk) begin
        if (reset) lfsr <= LFSR_SEED;
        else       lfsr <= lfsr_next;
    end

    // The state register describes the coming cycle: DRAIN means the head
    // is popped at the end of that cycle. Deciding from the post-update
    // occupancy puts the first pop one cycle after the first write.
    always_ff @(posedge clk) begin
        if (reset) st_q <= SINK_ST_IDLE;
        else       st_q <= st_d;
    end

    always_comb begin
        st_d = SINK_ST_IDLE;
        if (fifo_count_next != '0) begin
            st_d = go_next ? SINK_ST_DRAIN : SINK_ST_STALL;
        end
    end

    // Output tap, destination check and traffic counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            rx_count  <= '0;
            err_count <= '0;
            err_flag  <= 1'b0;
        end else begin
            out_valid <= pop;
            if (pop) begin
                out_data <= head;
                if (rx_count != '1) rx_count <= rx_count + 20'd1;
                if (head[ADDR_SZ-1:0] != MY_ADDR) begin
                    if (err_count != '1) err_count <= err_count + 16'd1;
                    err_flag <= 1'b1;
                end
            end
        end
    end

`ifdef SINK_LATENCY_EN
    logic [TS_W-1:0] ts_q;
    logic [TS_W-1:0] lat;
    logic [32:0]     sum_ext;

    // Modulo subtraction handles timestamp wrap for latencies < 2^TS_W.
    assign lat     = ts_q - head[ADDR_SZ +: TS_W];
    assign sum_ext = {1'b0, lat_sum} + 33'(lat);

    always_ff @(posedge clk) begin
        if (reset) begin
            ts_q    <= '0;
            lat_sum <= '0;
            lat_max <= '0;
        end else begin
            ts_q <= ts_q + TS_W'(1);
            if (pop) begin
                lat_sum <= sum_ext[32] ? 32'hFFFF_FFFF : sum_ext[31:0];
                if (lat > lat_max) lat_max <= lat;
            end
        end
    end
`else
    assign lat_sum = '0;
    assign lat_max = '0;
`endif

endmodule

// File: tb/tb_par_checking_sink.sv
// Directed bench for par_checking_sink. Three instances share one clock:
//   dut_a : ID=4, SINK_HOSP=255 (drains every cycle)
//   dut_b : ID=4, SINK_HOSP=0   (never drains)
//   dut_c : ID=0, SINK_HOSP=2   (drains only when the LFSR reads 1, i.e.
//           once per 255-cycle LFSR period)
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge.
module tb_par_checking_sink;
    import par_checking_sink_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_a, rst_b, rst_c;
    logic [FLIT_W-1:0] in_data_a, in_data_b, in_data_c;
    logic              in_valid_a, in_valid_b, in_valid_c;
    logic              busy_a, busy_b, busy_c;
    logic [FLIT_W-1:0] out_data_a, out_data_b, out_data_c;
    logic              out_valid_a, out_valid_b, out_valid_c;
    logic [19:0]       rx_a, rx_b, rx_c;
    logic [15:0]       err_a, err_b, err_c;
    logic              flag_a, flag_b, flag_c;
    logic [31:0]       lsum_a, lsum_b, lsum_c;
    logic [15:0]       lmax_a, lmax_b, lmax_c;
    logic [1:0]        state_a, state_b, state_c;

    par_checking_sink #(.ID(4), .SINK_HOSP(255), .DEPTH(4), .TS_W(16)) dut_a (
        .clk(clk), .reset(rst_a), .in_data(in_data_a), .in_valid(in_valid_a),
        .busy(busy_a), .out_data(out_data_a), .out_valid(out_valid_a),
        .rx_count(rx_a), .err_count(err_a), .err_flag(flag_a),
        .lat_sum(lsum_a), .lat_max(lmax_a), .state(state_a));

    par_checking_sink #(.ID(4), .SINK_HOSP(0), .DEPTH(4), .TS_W(16)) dut_b (
        .clk(clk), .reset(rst_b), .in_data(in_data_b), .in_valid(in_valid_b),
        .busy(busy_b), .out_data(out_data_b), .out_valid(out_valid_b),
        .rx_count(rx_b), .err_count(err_b), .err_flag(flag_b),
        .lat_sum(lsum_b), .lat_max(lmax_b), .state(state_b));

    par_checking_sink #(.ID(0), .SINK_HOSP(2), .DEPTH(4), .TS_W(16)) dut_c (
        .clk(clk), .reset(rst_c), .in_data(in_data_c), .in_valid(in_valid_c),
        .busy(busy_c), .out_data(out_data_c), .out_valid(out_valid_c),
        .rx_count(rx_c), .err_count(err_c), .err_flag(flag_c),
        .lat_sum(lsum_c), .lat_max(lmax_c), .state(state_c));

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [FLIT_W-1:0] mk(input logic [HDR_SZ-1:0] h,
                                             input logic [PL_SZ-1:0] p,
                                             input logic [ADDR_SZ-1:0] d);
        return {h, p, d};
    endfunction

    // ---------------- scoreboards ----------------
    logic [FLIT_W-1:0] exp_a[$];
    logic [FLIT_W-1:0] exp_c[$];
    int pops_a = 0, pops_b = 0, pops_c = 0;
    bit busy_seen_a = 1'b0;

    always @(negedge clk) begin
        if (rst_a) begin
            exp_a.delete();
        end else begin
            if (out_valid_a) begin
                pops_a++;
                if (exp_a.size() == 0) check("a_spurious_pop", 32'(out_valid_a), 32'd0);
                else                   check("a_out_data", 32'(out_data_a), 32'(exp_a.pop_front()));
            end
            if (in_valid_a && !busy_a) exp_a.push_back(in_data_a);
            if (busy_a) busy_seen_a = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (!rst_b && out_valid_b) pops_b++;
    end

    always @(negedge clk) begin
        if (rst_c) begin
            exp_c.delete();
        end else begin
            if (out_valid_c) begin
                pops_c++;
                if (exp_c.size() == 0) check("c_spurious_pop", 32'(out_valid_c), 32'd0);
                else                   check("c_out_data", 32'(out_data_c), 32'(exp_c.pop_front()));
            end
            if (in_valid_c && !busy_c) exp_c.push_back(in_data_c);
        end
    end

    // Timestamp model: cycles since reset release, as the sink counts them.
    logic [15:0] ts_a;
    always @(posedge clk) begin
        if (rst_a) ts_a <= 16'd0;
        else       ts_a <= ts_a + 16'd1;
    end

    // ---------------- drivers ----------------
    task automatic send_a(input logic [FLIT_W-1:0] f);
        in_data_a  = f;
        in_valid_a = 1'b1;
        tick(1);
        in_valid_a = 1'b0;
    endtask

    task automatic push_b(input int i);
        in_data_b  = mk(2'd1, 24'(i + 32), 4'd4);
        in_valid_b = 1'b1;
        @(negedge clk);
        check("b_busy_pre", 32'(busy_b), 32'd0);
        @(posedge clk);
        #1;
        in_valid_b = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int n;
    logic [31:0] exp_sum;
    logic [15:0] exp_max;

    initial begin
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        in_data_a = '0; in_data_b = '0; in_data_c = '0;
        in_valid_a = 1'b0; in_valid_b = 1'b0; in_valid_c = 1'b0;
        tick(3);
        rst_a = 1'b0;
        rst_b = 1'b0;

        // ---- reset state ----
        @(negedge clk);
        check("rst_busy",      32'(busy_a),      32'd0);
        check("rst_out_valid", 32'(out_valid_a), 32'd0);
        check("rst_out_data",  32'(out_data_a),  32'd0);
        check("rst_rx",        32'(rx_a),        32'd0);
        check("rst_err",       32'(err_a),       32'd0);
        check("rst_flag",      32'(flag_a),      32'd0);
        check("rst_state",     32'(state_a),     32'(SINK_ST_IDLE));
        check("rst_lat_sum",   lsum_a,           32'd0);
        check("rst_lat_max",   32'(lmax_a),      32'd0);

        // ---- 10 good flits back-to-back, drain every cycle ----
        @(posedge clk);
        #1;
        for (int i = 0; i < 10; i++) send_a(mk(2'(i), 24'(24'h100 + i), 4'd4));
        tick(4);
        @(negedge clk);
        check("t1_rx",        32'(rx_a),         32'd10);
        check("t1_err",       32'(err_a),        32'd0);
        check("t1_flag",      32'(flag_a),       32'd0);
        check("t1_busy_seen", 32'(busy_seen_a),  32'd0);
        check("t1_pops",      32'(pops_a),       32'd10);
        check("t1_q_left",    32'(exp_a.size()), 32'd0);
        check("t1_state",     32'(state_a),      32'(SINK_ST_IDLE));
`ifndef SINK_LATENCY_EN
        check("t1_lat_sum",   lsum_a,            32'd0);
        check("t1_lat_max",   32'(lmax_a),       32'd0);
`endif

        // ---- one misrouted flit among good ones ----
        @(posedge clk);
        #1;
        rst_a = 1'b1;
        tick(2);
        rst_a  = 1'b0;
        pops_a = 0;
        send_a(mk(2'd0, 24'h000111, 4'd4));
        send_a(mk(2'd0, 24'h000222, 4'd4));
        send_a(mk(2'd3, 24'h000333, 4'd7));
        send_a(mk(2'd0, 24'h000444, 4'd4));
        send_a(mk(2'd0, 24'h000555, 4'd4));
        tick(4);
        @(negedge clk);
        check("t3_err",  32'(err_a),  32'd1);
        check("t3_flag", 32'(flag_a), 32'd1);
        check("t3_rx",   32'(rx_a),   32'd5);
        @(posedge clk);
        #1;
        send_a(mk(2'd0, 24'h000666, 4'd4));
        tick(4);
        @(negedge clk);
        check("t3_flag_sticky", 32'(flag_a),       32'd1);
        check("t3_err_after",   32'(err_a),        32'd1);
        check("t3_rx_after",    32'(rx_a),         32'd6);
        check("t3_q_left",      32'(exp_a.size()), 32'd0);

`ifdef SINK_LATENCY_EN
        // ---- latency: stamp = now-5, one cycle in the buffer -> 6 ----
        @(posedge clk);
        #1;
        rst_a = 1'b1;
        tick(2);
        rst_a = 1'b0;
        tick(3);
        send_a(mk(2'd0, 24'(ts_a - 16'd5), 4'd4));
        exp_sum = 32'd6;
        exp_max = 16'd6;
        tick(3);
        @(negedge clk);
        check("lat_max_1", 32'(lmax_a), 32'(exp_max));
        check("lat_sum_1", lsum_a,      exp_sum);
        @(posedge clk);
        #1;
        send_a(mk(2'd0, 24'(ts_a - 16'd2), 4'd4));
        exp_sum = exp_sum + 32'd3;
        tick(2);
        send_a(mk(2'd0, 24'(ts_a - 16'd20), 4'd4));
        exp_sum = exp_sum + 32'd21;
        exp_max = 16'd21;
        tick(3);
        @(negedge clk);
        check("lat_max_2", 32'(lmax_a), 32'(exp_max));
        check("lat_sum_2", lsum_a,      exp_sum);
`endif

        // ---- never drain: fill, hold, stall ----
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) push_b(i);
        in_data_b  = mk(2'd1, 24'd36, 4'd4);
        in_valid_b = 1'b1;
        @(negedge clk);
        check("b_busy_full", 32'(busy_b), 32'd1);
        @(posedge clk);
        #1;
        in_data_b = mk(2'd1, 24'd37, 4'd4);
        tick(3);
        @(negedge clk);
        check("b_busy_hold", 32'(busy_b),  32'd1);
        check("b_state",     32'(state_b), 32'(SINK_ST_STALL));
        check("b_no_pulse",  32'(pops_b),  32'd0);
        check("b_rx",        32'(rx_b),    32'd0);

        // ---- reset while full, then reset with 3 flits buffered ----
        @(posedge clk);
        #1;
        in_valid_b = 1'b0;
        rst_b = 1'b1;
        tick(1);
        rst_b = 1'b0;
        @(negedge clk);
        check("b_rst_busy",  32'(busy_b),  32'd0);
        check("b_rst_rx",    32'(rx_b),    32'd0);
        check("b_rst_state", 32'(state_b), 32'(SINK_ST_IDLE));
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) push_b(i + 8);
        rst_b = 1'b1;
        tick(1);
        rst_b = 1'b0;
        @(negedge clk);
        check("b_rst3_busy", 32'(busy_b), 32'd0);
        check("b_rst3_rx",   32'(rx_b),   32'd0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) push_b(i + 16);
        in_data_b  = mk(2'd1, 24'd19, 4'd4);
        in_valid_b = 1'b1;
        tick(1);
        in_valid_b = 1'b0;
        @(negedge clk);
        check("b_refill_full", 32'(busy_b), 32'd1);
        check("b_no_pulse_2",  32'(pops_b), 32'd0);

        // ---- full buffer, rare drain, in_valid held ----
        @(posedge clk);
        #1;
        rst_c = 1'b1;
        tick(2);
        rst_c = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_data_c  = mk(2'd2, 24'(24'h200 + i), 4'd0);
            in_valid_c = 1'b1;
            @(negedge clk);
            check("c_busy_pre", 32'(busy_c), 32'd0);
            @(posedge clk);
            #1;
        end
        in_data_c = mk(2'd2, 24'h000204, 4'd0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid_c && n < 400);
        check("c_pop_seen",       32'(out_valid_c), 32'd1);
        // The pop freed a slot but nothing was written in that cycle.
        check("c_busy_after_pop", 32'(busy_c),      32'd0);
        check("c_rx_one",         32'(rx_c),        32'd1);
        @(posedge clk);
        #1;
        in_valid_c = 1'b0;
        @(negedge clk);
        check("c_busy_refill",    32'(busy_c),      32'd1);
        n = 0;
        while (pops_c < 5 && n < 1300) begin
            @(negedge clk);
            n++;
        end
        check("c_pops",   32'(pops_c),       32'd5);
        check("c_rx",     32'(rx_c),         32'd5);
        check("c_err",    32'(err_c),        32'd0);
        check("c_q_left", 32'(exp_c.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
